mgt_01_wb_arbiter: RTL and testbench
====================================

MGT_01_WB_ARBITER -- requirements
Module: MGT_01_wb_arbiter

Interface
REQ-001 Parameter REQUESTERS, default 4, SHALL set the number of writeback requesters (functional units), legal range 2..8.
REQ-002 Parameter WRITE_PORTS, default 2, SHALL set the number of integer register file write ports driven, legal range 1..REQUESTERS.
REQ-003 Port clk_i, input, 1, SHALL be the single clock; all state is on its rising edge.
REQ-004 Port rst_i, input, 1, SHALL be the reset, asynchronous and active-high.
REQ-005 Port clk_en_i, input, 1, SHALL be the clock enable; low means stall.
REQ-006 Port req_valid_i, input, [REQUESTERS], SHALL flag a writeback request per requester.
REQ-007 Port req_addr_i, input, i_register_e [REQUESTERS], SHALL carry the destination register per requester.
REQ-008 Port req_data_i, input, data_bus_t [REQUESTERS], SHALL carry the writeback data per requester.
REQ-009 Port req_ready_o, output, [REQUESTERS], SHALL carry the per-requester grant; a transfer occurs when valid and ready are both high.
REQ-010 Port we_o, output, [WRITE_PORTS], SHALL drive the register file write enables.
REQ-011 Port wr_iaddr_o, output, i_register_e [WRITE_PORTS], SHALL drive the register file write addresses.
REQ-012 Port wr_idata_o, output, data_bus_t [WRITE_PORTS], SHALL drive the register file write data.
REQ-013 Port issue_valid_i, input, 1, SHALL flag an issued instruction with an integer destination.
REQ-014 Port issue_addr_i, input, i_register_e, SHALL carry the issued destination register.
REQ-015 Port busy_o, output, [XLEN-1:0], SHALL expose the pending-write scoreboard; busy_o[0] is always 0.

Function
REQ-016 Requesters SHALL hold valid, addr and data stable until their handshake completes.
REQ-017 Each cycle, with clk_en_i high, requesters SHALL be scanned in round-robin order starting at index rr_ptr.
REQ-018 At most WRITE_PORTS non-X0 requests SHALL be granted per cycle.
REQ-019 req_ready_o SHALL be combinational from the current inputs and state, with no dependence on the current-cycle grant.
REQ-020 Requests addressed to X0 SHALL always be granted, consume no write port and never assert we_o.
REQ-021 When two valid requests in one cycle target the same non-X0 register, only the one earlier in scan order SHALL be granted; the other waits.
REQ-022 Granted non-X0 requests SHALL map to write ports 0,1,... in scan order; unused ports SHALL have we_o=0.
REQ-023 Write port outputs SHALL be registered: latency is exactly 1 cycle from handshake to we_o high.
REQ-024 we_o SHALL be high for exactly one cycle per granted write.
REQ-025 rr_ptr SHALL advance to (index of last granted requester + 1) mod REQUESTERS, and SHALL hold when nothing is granted.
REQ-026 issue_valid_i with a non-X0 address SHALL set the matching busy bit at the next edge; issue to X0 SHALL be ignored.
REQ-027 A granted non-X0 writeback SHALL clear the matching busy bit at the same edge that registers the write.
REQ-028 A simultaneous issue and writeback to the same register SHALL leave the bit set (set wins).
REQ-029 With clk_en_i low:
- all req_ready_o are 0;
- the write port registers load we_o=0;
- rr_ptr and busy_o hold;
- issue_valid_i is ignored.

Reset
REQ-030 While rst_i is high, and immediately on its assertion, the block SHALL drive:
- we_o=0, wr_iaddr_o=X0, wr_idata_o=0;
- req_ready_o=0;
- rr_ptr=0, busy_o=0.
REQ-031 Reset asserted mid-transfer SHALL discard all in-flight grants; requesters re-request after reset.
REQ-032 The first grant after rst_i deasserts SHALL be possible on the first enabled rising edge.

Verification
REQ-033 Reset, then req 0..3 all valid to x1..x4 with rr_ptr=0 -> cycle 0: ready=0011; next cycle: we_o=11 for x1,x2; then ready=1100 -> x3,x4 written.
REQ-034 Req0 and req1 both to x5 (data A, B) -> req0 granted and written first; B written one cycle later; x5 final value B.
REQ-035 Req2 to X0 plus req0 and req1 to x6, x7 -> all three ready in one cycle; we_o only for x6, x7.
REQ-036 Issue x9, then two cycles later writeback x9 plus issue x9 in the same cycle -> busy_o[9] stays 1; a later lone writeback clears it.
REQ-037 clk_en_i low for 3 cycles with req0 valid -> ready=0, we_o=0, busy_o unchanged; grant on the first cycle after clk_en_i returns high.
REQ-038 rst_i pulsed asynchronously between edges while we_o=1 -> we_o drops to 0 immediately; busy_o=0.

Source files
------------

// File: rtl/mgt_01_wb_arbiter.sv
// Writeback arbiter: round-robin grant of functional-unit writebacks onto the
// integer register file write ports, plus a pending-write (busy) scoreboard.

package mgt_01_wb_arbiter_pkg;
  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] data_bus_t;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } i_register_e;
endpackage

module mgt_01_wb_arbiter
  import mgt_01_wb_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = 4,
  parameter int WRITE_PORTS = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clk_en_i,
  input  logic [REQUESTERS-1:0]  req_valid_i,
  input  i_register_e            req_addr_i [REQUESTERS],
  input  data_bus_t              req_data_i [REQUESTERS],
  output logic [REQUESTERS-1:0]  req_ready_o,
  output logic [WRITE_PORTS-1:0] we_o,
  output i_register_e            wr_iaddr_o [WRITE_PORTS],
  output data_bus_t              wr_idata_o [WRITE_PORTS],
  input  logic                   issue_valid_i,
  input  i_register_e            issue_addr_i,
  output logic [XLEN-1:0]        busy_o
);

  localparam int PTR_W = $clog2(REQUESTERS);

  logic [PTR_W-1:0]       rr_q, rr_d;
  logic [XLEN-1:0]        busy_q, busy_d;
  logic [WRITE_PORTS-1:0] we_q, we_d;
  i_register_e            waddr_q [WRITE_PORTS];
  i_register_e            waddr_d [WRITE_PORTS];
  data_bus_t              wdata_q [WRITE_PORTS];
  data_bus_t              wdata_d [WRITE_PORTS];
  logic [REQUESTERS-1:0]  ready;

  // Modulo-REQUESTERS increment that also works for non-power-of-two counts.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(REQUESTERS - 1)) ? '0 : v + PTR_W'(1);
  endfunction

  // Round-robin scan: grant X0 requests freely, pack non-X0 grants onto the
  // write ports in scan order, and block a later request to a register that an
  // earlier valid request already targets so writes to it stay in order.
  always_comb begin : grant_scan
    logic [PTR_W-1:0] idx;
    logic [31:0]      claimed;
    logic             placed;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    ready   = '0;
    we_d    = '0;
    rr_d    = rr_q;
    idx     = rr_q;
    claimed = '0;
    placed  = 1'b0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      waddr_d[p] = X0;
      wdata_d[p] = '0;
    end
    if (clk_en_i && !rst_i) begin
      for (int k = 0; k < REQUESTERS; k++) begin
        if (req_valid_i[idx]) begin
          if (req_addr_i[idx] == X0) begin
            ready[idx] = 1'b1;
            rr_d       = wrap_inc(idx);
          end else begin
            if (!claimed[req_addr_i[idx]] && !(&we_d)) begin
              ready[idx] = 1'b1;
              rr_d       = wrap_inc(idx);
              placed     = 1'b0;
              for (int p = 0; p < WRITE_PORTS; p++) begin
                if (!placed && !we_d[p]) begin
                  we_d[p]    = 1'b1;
                  waddr_d[p] = req_addr_i[idx];
                  wdata_d[p] = req_data_i[idx];
                  placed     = 1'b1;
                end
              end
            end
            claimed[req_addr_i[idx]] = 1'b1;
          end
        end
        idx = wrap_inc(idx);
      end
    end
  end

  // Busy scoreboard next state: clear on granted writes, then set on issue so
  // a same-cycle issue to the same register keeps the bit set.
  always_comb begin : busy_next
    busy_d = busy_q;
    if (clk_en_i) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (we_d[p]) busy_d[waddr_d[p]] = 1'b0;
      end
      if (issue_valid_i && issue_addr_i != X0) busy_d[issue_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State and write-port registers; a stall loads we=0 because we_d is gated.
  always_ff @(posedge clk_i or posedge rst_i) begin : state_regs
    if (rst_i) begin
      rr_q   <= '0;
      busy_q <= '0;
      we_q   <= '0;
      for (int p = 0; p < WRITE_PORTS; p++) begin
        waddr_q[p] <= X0;
        wdata_q[p] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      we_q <= we_d;
      for (int p = 0; p < WRITE_PORTS; p++) begin
        waddr_q[p] <= waddr_d[p];
        wdata_q[p] <= wdata_d[p];
      end
      if (clk_en_i) begin
        rr_q   <= rr_d;
        busy_q <= busy_d;
      end
    end
  end

  assign req_ready_o = ready;
  assign we_o        = we_q;
  assign wr_iaddr_o  = waddr_q;
  assign wr_idata_o  = wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mgt_01_wb_arbiter.sv
// Directed bench for mgt_01_wb_arbiter: expected write-port traffic is queued
// when a request cycle is driven and compared after the following edge.

module tb_mgt_01_wb_arbiter;
  import mgt_01_wb_arbiter_pkg::*;

  typedef struct {
    logic [1:0]  we;
    i_register_e a0;
    data_bus_t   d0;
    i_register_e a1;
    data_bus_t   d1;
  } port_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  i_register_e req_addr [4];
  data_bus_t   req_data [4];
  logic [1:0]  we;
  i_register_e wr_iaddr [2];
  data_bus_t   wr_idata [2];
  logic        issue_valid;
  i_register_e issue_addr;
  logic [31:0] busy;

  port_t       exp_q [$];
  data_bus_t   rf [32];
  int          n_checks = 0;
  int          n_errors = 0;

  mgt_01_wb_arbiter #(.REQUESTERS(4), .WRITE_PORTS(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clk_en_i     (clk_en),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .we_o         (we),
    .wr_iaddr_o   (wr_iaddr),
    .wr_idata_o   (wr_idata),
    .issue_valid_i(issue_valid),
    .issue_addr_i (issue_addr),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic port_t mk(input logic [1:0] w, input i_register_e a0, input data_bus_t d0,
                               input i_register_e a1, input data_bus_t d1);
    port_t r;
    r.we = w; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1;
    return r;
  endfunction

  // One arbitration cycle: check grants, queue the expected writes, take the
  // edge, retire handshaken requests, then compare the registered writes.
  task automatic cycle(input string tag, input logic [3:0] exp_rdy, input port_t exp_wr);
    logic [3:0] hs;
    port_t      e;
    #1;
    check({tag, "_rdy"}, 64'(req_ready), 64'(exp_rdy));
    exp_q.push_back(exp_wr);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~hs;
    e = exp_q.pop_front();
    check({tag, "_we"}, 64'(we), 64'(e.we));
    if (e.we[0]) begin
      check({tag, "_a0"}, 64'(wr_iaddr[0]), 64'(e.a0));
      check({tag, "_d0"}, 64'(wr_idata[0]), 64'(e.d0));
    end
    if (e.we[1]) begin
      check({tag, "_a1"}, 64'(wr_iaddr[1]), 64'(e.a1));
      check({tag, "_d1"}, 64'(wr_idata[1]), 64'(e.d1));
    end
    for (int p = 0; p < 2; p++) begin
      if (we[p]) rf[wr_iaddr[p]] = wr_idata[p];
    end
  endtask

  initial begin
    port_t idle;
    idle = mk(2'b00, X0, '0, X0, '0);
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Reset with requests already pending: no grants, outputs quiet.
    rst = 1'b1; clk_en = 1'b1; issue_valid = 1'b0; issue_addr = X0;
    req_valid = 4'b1111;
    req_addr[0] = X1; req_addr[1] = X2; req_addr[2] = X3; req_addr[3] = X4;
    req_data[0] = 32'h1111_0001; req_data[1] = 32'h2222_0002;
    req_data[2] = 32'h3333_0003; req_data[3] = 32'h4444_0004;
    #3;
    check("rst_ready", 64'(req_ready), 64'(4'b0000));
    check("rst_we",    64'(we),        64'(2'b00));
    check("rst_busy",  64'(busy),      64'(32'h0));
    check("rst_addr0", 64'(wr_iaddr[0]), 64'(X0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Four writes, two ports: first pair then second pair.
    cycle("rr_c0", 4'b0011, mk(2'b11, X1, 32'h1111_0001, X2, 32'h2222_0002));
    cycle("rr_c1", 4'b1100, mk(2'b11, X3, 32'h3333_0003, X4, 32'h4444_0004));

    // Same-register conflict: earlier in scan wins, later written next cycle.
    req_valid = 4'b0011;
    req_addr[0] = X5; req_data[0] = 32'hAAAA_0005;
    req_addr[1] = X5; req_data[1] = 32'hBBBB_0005;
    cycle("conf_c0", 4'b0001, mk(2'b01, X5, 32'hAAAA_0005, X0, '0));
    cycle("conf_c1", 4'b0010, mk(2'b01, X5, 32'hBBBB_0005, X0, '0));
    check("conf_final_x5", 64'(rf[5]), 64'(32'hBBBB_0005));

    // X0 request consumes no port: three grants, two writes.
    req_valid = 4'b0111;
    req_addr[0] = X6; req_data[0] = 32'h0000_0606;
    req_addr[1] = X7; req_data[1] = 32'h0000_0707;
    req_addr[2] = X0; req_data[2] = 32'hDEAD_0000;
    cycle("x0_c0", 4'b0111, mk(2'b11, X6, 32'h0000_0606, X7, 32'h0000_0707));

    // Port limit with wrap-around scan starting at requester 2.
    req_valid = 4'b1111;
    req_addr[0] = X10; req_data[0] = 32'h0000_0A0A;
    req_addr[1] = X11; req_data[1] = 32'h0000_0B0B;
    req_addr[2] = X8;  req_data[2] = 32'h0000_0808;
    req_addr[3] = X0;  req_data[3] = 32'h0000_0000;
    cycle("wrap_c0", 4'b1101, mk(2'b11, X8, 32'h0000_0808, X10, 32'h0000_0A0A));
    cycle("wrap_c1", 4'b0010, mk(2'b01, X11, 32'h0000_0B0B, X0, '0));

    // Busy scoreboard: issue, ignored X0 issue, set-wins collision, clear.
    issue_valid = 1'b1; issue_addr = X9;
    cycle("busy_issue", 4'b0000, idle);
    check("busy_set9", 64'(busy), 64'(32'h0000_0200));
    issue_addr = X0;
    cycle("busy_issue_x0", 4'b0000, idle);
    check("busy_x0_ignored", 64'(busy), 64'(32'h0000_0200));
    issue_addr = X9;
    req_valid = 4'b0001; req_addr[0] = X9; req_data[0] = 32'h0000_0909;
    cycle("busy_coll", 4'b0001, mk(2'b01, X9, 32'h0000_0909, X0, '0));
    check("busy_set_wins", 64'(busy), 64'(32'h0000_0200));
    issue_valid = 1'b0;
    req_valid = 4'b0010; req_addr[1] = X9; req_data[1] = 32'h0000_9999;
    cycle("busy_clear", 4'b0010, mk(2'b01, X9, 32'h0000_9999, X0, '0));
    check("busy_cleared", 64'(busy), 64'(32'h0));

    // Stall: three disabled cycles freeze everything, then grant resumes.
    issue_valid = 1'b1; issue_addr = X13;
    cycle("stall_pre", 4'b0000, idle);
    check("stall_busy13", 64'(busy), 64'(32'h0000_2000));
    clk_en = 1'b0; issue_addr = X14;
    req_valid = 4'b0001; req_addr[0] = X12; req_data[0] = 32'h0000_0C0C;
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("stall%0d", i), 4'b0000, idle);
      check($sformatf("stall%0d_busy", i), 64'(busy), 64'(32'h0000_2000));
    end
    clk_en = 1'b1; issue_valid = 1'b0;
    cycle("stall_resume", 4'b0001, mk(2'b01, X12, 32'h0000_0C0C, X0, '0));

    // Asynchronous reset between edges while a write is on the ports.
    req_valid = 4'b0010; req_addr[1] = X15; req_data[1] = 32'h0000_0F0F;
    cycle("arst_pre", 4'b0010, mk(2'b01, X15, 32'h0000_0F0F, X0, '0));
    req_valid = 4'b0111;
    req_addr[0] = X16; req_data[0] = 32'h0000_1616;
    req_addr[1] = X17; req_data[1] = 32'h0000_1717;
    req_addr[2] = X18; req_data[2] = 32'h0000_1818;
    #2;
    rst = 1'b1;
    #1;
    check("arst_we",    64'(we),          64'(2'b00));
    check("arst_addr0", 64'(wr_iaddr[0]), 64'(X0));
    check("arst_data0", 64'(wr_idata[0]), 64'(32'h0));
    check("arst_ready", 64'(req_ready),   64'(4'b0000));
    check("arst_busy",  64'(busy),        64'(32'h0));
    @(posedge clk); #1;
    rst = 1'b0;
    cycle("arst_rr0", 4'b0011, mk(2'b11, X16, 32'h0000_1616, X17, 32'h0000_1717));
    cycle("arst_rr1", 4'b0100, mk(2'b01, X18, 32'h0000_1818, X0, '0));

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
